// File: rtl/college_pkg.sv
// Shared types and constants for the classroom score arbiter.
package college_pkg;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 2;

    typedef enum logic [1:0] {
        TEACHER   = 2'd0,
        PRINCIPAL = 2'd1,
        STUDENT   = 2'd2
    } requester_e;

    typedef enum logic [1:0] {
        MATH    = 2'd0,
        PHYSICS = 2'd1,
        LAB     = 2'd2,
        BAD     = 2'd3
    } subject_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Next requester index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational winner, registered last-grantee pointer.
module rr_arbiter3
    import college_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [1:0]         o_gnt_idx
);

    logic [1:0] r_last;
    logic [1:0] w_p0;
    logic [1:0] w_p1;
    logic [1:0] w_p2;

    // Search order begins just after the last grantee and wraps around.
    always_comb begin
        w_p0      = rr_next(r_last);
        w_p1      = rr_next(w_p0);
        w_p2      = rr_next(w_p1);
        o_gnt_idx = w_p0;
        if (i_req[w_p0])
            o_gnt_idx = w_p0;
        else if (i_req[w_p1])
            o_gnt_idx = w_p1;
        else if (i_req[w_p2])
            o_gnt_idx = w_p2;
        o_gnt_oh = (|i_req) ? (3'b001 << o_gnt_idx) : 3'b000;
    end

    // Pointer starts at the student so the teacher is searched first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= STUDENT;
        else if (i_update && (|i_req))
            r_last <= o_gnt_idx;
    end

endmodule

// File: rtl/college_score_arbiter.sv
// Serialises teacher/principal/student access to the classroom score bank.
module college_score_arbiter
    import college_pkg::*;
#(
    parameter int                 SCORE_W   = 8,
    parameter int                 MAX_SCORE = 100,
    parameter logic [SCORE_W-1:0] MATH_RST  = '0,
    parameter logic [SCORE_W-1:0] PHYS_RST  = '0,
    parameter logic [SCORE_W-1:0] LAB_RST   = '0
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    addr,
    input  logic [NUM_REQ-1:0][SCORE_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                rvalid,
    output logic [NUM_REQ-1:0]                err,
    output logic [SCORE_W-1:0]                rdata,
    output logic [SCORE_W-1:0]                classroom_math,
    output logic [SCORE_W-1:0]                classroom_physics,
    output logic [SCORE_W-1:0]                classroom_lab
);

    localparam logic [SCORE_W-1:0] CLAMP = SCORE_W'(MAX_SCORE);

    state_e             r_state;
    state_e             w_state_next;
    logic [1:0]         r_idx;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [SCORE_W-1:0] r_wdata;
    logic [SCORE_W-1:0] r_math;
    logic [SCORE_W-1:0] r_phys;
    logic [SCORE_W-1:0] r_lab;
    logic [SCORE_W-1:0] r_rdata;
    logic               r_err;

    logic [NUM_REQ-1:0] w_win_oh;
    logic [1:0]         w_win_idx;
    logic               w_start;
    logic               w_err;
    logic               w_do_write;
    logic [SCORE_W-1:0] w_wval;
    logic [SCORE_W-1:0] w_rsel;
    logic [SCORE_W-1:0] w_result;
    logic [NUM_REQ-1:0] w_idx_oh;

    assign w_start  = (r_state == IDLE) && (|req);
    assign w_idx_oh = 3'b001 << r_idx;

    rr_arbiter3 u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_update  (w_start),
        .o_gnt_oh  (w_win_oh),
        .o_gnt_idx (w_win_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state: IDLE waits for any request, then a fixed ACCESS -> RESP pass.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Capture the winner's command at the IDLE sample; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_idx   <= w_win_idx;
            r_we    <= we[w_win_idx];
            r_addr  <= addr[w_win_idx];
            r_wdata <= wdata[w_win_idx];
        end
    end

    // Rights check, clamp and read mux for the latched command.
    always_comb begin
        w_err      = (subject_e'(r_addr) == BAD) || (r_we && (r_idx == STUDENT));
        w_do_write = r_we && !w_err;
        w_wval     = (r_wdata > CLAMP) ? CLAMP : r_wdata;
        case (subject_e'(r_addr))
            MATH:    w_rsel = r_math;
            PHYSICS: w_rsel = r_phys;
            LAB:     w_rsel = r_lab;
            default: w_rsel = '0;
        endcase
        if (w_err)
            w_result = '0;
        else if (r_we)
            w_result = w_wval;
        else
            w_result = w_rsel;
    end

    // Score bank: a permitted write commits on the edge that ends ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_math <= MATH_RST;
            r_phys <= PHYS_RST;
            r_lab  <= LAB_RST;
        end else if ((r_state == ACCESS) && w_do_write) begin
            case (subject_e'(r_addr))
                MATH:    r_math <= w_wval;
                PHYSICS: r_phys <= w_wval;
                LAB:     r_lab  <= w_wval;
                default: ;
            endcase
        end
    end

    // Response registers loaded at the end of ACCESS, presented during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_rdata <= w_result;
            r_err   <= w_err;
        end
    end

    // Outputs decoded from state so a reset clears them immediately.
    always_comb begin
        gnt    = (r_state == ACCESS) ? w_idx_oh : '0;
        rvalid = (r_state == RESP) ? w_idx_oh : '0;
        err    = ((r_state == RESP) && r_err) ? w_idx_oh : '0;
        rdata  = (r_state == RESP) ? r_rdata : '0;
    end

    assign classroom_math    = r_math;
    assign classroom_physics = r_phys;
    assign classroom_lab     = r_lab;

endmodule

// File: tb/tb_college_score_arbiter.sv
// Scoreboard bench for college_score_arbiter: directed requests, decoupled monitor.
module tb_college_score_arbiter;
    import college_pkg::*;

    localparam logic [7:0] LAB_R = 8'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       req = '0;
    logic [2:0]       we  = '0;
    logic [2:0][1:0]  addr  = '0;
    logic [2:0][7:0]  wdata = '0;
    logic [2:0]       gnt;
    logic [2:0]       rvalid;
    logic [2:0]       err;
    logic [7:0]       rdata;
    logic [7:0]       classroom_math;
    logic [7:0]       classroom_physics;
    logic [7:0]       classroom_lab;

    college_score_arbiter #(
        .SCORE_W   (8),
        .MAX_SCORE (100),
        .MATH_RST  (8'd0),
        .PHYS_RST  (8'd0),
        .LAB_RST   (LAB_R)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .we                (we),
        .addr              (addr),
        .wdata             (wdata),
        .gnt               (gnt),
        .rvalid            (rvalid),
        .err               (err),
        .rdata             (rdata),
        .classroom_math    (classroom_math),
        .classroom_physics (classroom_physics),
        .classroom_lab     (classroom_lab)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       e;
        logic [7:0] d;
    } rsp_t;

    rsp_t rsp_q[$];
    int   gnt_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: compare every grant and response against the queued expectations.
    always @(negedge clk) begin
        rsp_t r;
        int   g;
        if (gnt !== 3'b000) begin
            if (gnt_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                g = gnt_q.pop_front();
                chk("gnt_order", 32'(gnt), 32'(3'b001 << g));
            end
        end
        if (rvalid !== 3'b000) begin
            $display("rsp rvalid=%b err=%b rdata=%0d", rvalid, err, rdata);
            if (rsp_q.size() == 0) begin
                chk("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rvalid_who", 32'(rvalid), 32'(3'b001 << r.idx));
                chk("err", 32'(err), r.e ? 32'(3'b001 << r.idx) : 32'd0);
                chk("rdata", 32'(rdata), 32'(r.d));
            end
        end else if (err !== 3'b000) begin
            chk("err_without_rvalid", 32'(err), 32'd0);
        end
    end

    task automatic set_req(input int r, input logic w, input logic [1:0] a, input logic [7:0] d);
        we[r]    = w;
        addr[r]  = a;
        wdata[r] = d;
        req[r]   = 1'b1;
    endtask

    task automatic expect_rsp(input int idx, input logic e, input logic [7:0] d);
        gnt_q.push_back(idx);
        rsp_q.push_back(rsp_t'{idx: idx, e: e, d: d});
    endtask

    // Requester behaviour: drop req once granted; bounded wait for the queues to empty.
    task automatic drain(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            req = req & ~gnt;
            if (req == 3'b000 && gnt_q.size() == 0 && rsp_q.size() == 0) break;
            n++;
            if (n > budget) begin
                chk("drain_timeout", 32'(n), 32'(budget));
                gnt_q.delete();
                rsp_q.delete();
                req = '0;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_math", 32'(classroom_math), 32'd0);
        chk("rst_phys", 32'(classroom_physics), 32'd0);
        chk("rst_lab", 32'(classroom_lab), 32'(LAB_R));
        rst = 1'b0;

        // Teacher alone writes math = 85, latency check
        @(negedge clk);
        set_req(0, 1'b1, 2'(MATH), 8'd85);
        expect_rsp(0, 1'b0, 8'd85);
        @(negedge clk);
        chk("t1_gnt_latency", 32'(gnt), 32'd1);
        req = '0;
        @(negedge clk);
        chk("t1_rvalid_latency", 32'(rvalid), 32'd1);
        drain(20);
        chk("t1_math", 32'(classroom_math), 32'd85);

        // All three at once on lab, fresh pointer
        pulse_reset();
        @(negedge clk);
        set_req(0, 1'b1, 2'(LAB), 8'd95);
        set_req(1, 1'b1, 2'(LAB), 8'd99);
        set_req(2, 1'b0, 2'(LAB), 8'd0);
        expect_rsp(0, 1'b0, 8'd95);
        expect_rsp(1, 1'b0, 8'd99);
        expect_rsp(2, 1'b0, 8'd99);
        drain(40);
        chk("t2_lab", 32'(classroom_lab), 32'd99);

        // Student write is refused
        @(negedge clk);
        set_req(2, 1'b1, 2'(PHYSICS), 8'd90);
        expect_rsp(2, 1'b1, 8'd0);
        drain(20);
        chk("t3_phys", 32'(classroom_physics), 32'd0);

        // Principal write clamps; teacher reads invalid address
        @(negedge clk);
        set_req(1, 1'b1, 2'(MATH), 8'd200);
        expect_rsp(1, 1'b0, 8'd100);
        drain(20);
        chk("t4_math_clamp", 32'(classroom_math), 32'd100);
        @(negedge clk);
        set_req(0, 1'b0, 2'(BAD), 8'd0);
        expect_rsp(0, 1'b1, 8'd0);
        drain(20);
        chk("t4_math_kept", 32'(classroom_math), 32'd100);

        // Teacher and student hold req for 12 cycles: grants alternate 0,2,0,2
        pulse_reset();
        @(negedge clk);
        set_req(0, 1'b0, 2'(LAB), 8'd0);
        set_req(2, 1'b0, 2'(LAB), 8'd0);
        expect_rsp(0, 1'b0, LAB_R);
        expect_rsp(2, 1'b0, LAB_R);
        expect_rsp(0, 1'b0, LAB_R);
        expect_rsp(2, 1'b0, LAB_R);
        repeat (12) @(posedge clk);
        @(negedge clk);
        req = '0;
        drain(20);

        // Reset during ACCESS of teacher write lab = 50
        @(negedge clk);
        set_req(0, 1'b1, 2'(LAB), 8'd50);
        gnt_q.push_back(0);
        @(negedge clk);
        chk("t6_in_access", 32'(gnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_gnt_cleared", 32'(gnt), 32'd0);
        req = '0;
        @(negedge clk);
        chk("t6_lab_reset", 32'(classroom_lab), 32'(LAB_R));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_quiet", 32'({gnt, rvalid}), 32'd0);
        end
        chk("t6_lab_kept", 32'(classroom_lab), 32'(LAB_R));
        @(negedge clk);
        set_req(0, 1'b1, 2'(LAB), 8'd50);
        expect_rsp(0, 1'b0, 8'd50);
        drain(20);
        chk("t6_lab_after", 32'(classroom_lab), 32'd50);

        chk("queues_empty", 32'(gnt_q.size() + rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
